// File: rtl/uart_apb_regif.sv
// -----------------------------------------------------------------------------
// uart_apb_regif
//   APB3 slave register bank and interrupt controller for a 16550-style UART.
//   It decodes bus accesses into the divisor and configuration registers, and
//   issues THR push and RBR pop handshakes to the TX/RX buffers. It also
//   builds the LSR and MSR status views and a registered, prioritised IIR/INTR.
//
//   Optional feature: define UART_SCR_EN to map an 8-bit scratch register at
//   offset 7. When it is undefined, offset 7 is unmapped: PSLVERR=1, PRDATA=0,
//   and writes are discarded.
//
// Ports
//   PCLK, PRESETn                 clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB3 request
//   PRDATA/PREADY/PSLVERR         APB3 response
//   DLR, IER, LCR, FCR, MCR       configuration outputs
//   tx_push/tx_data               THR write handshake to the TX buffer
//   rx_pop/rx_data                RBR read handshake to the RX buffer
//   rx_rdy, oe, pe, fe, bi, thre, temt   buffer/shifter status
//   fifo_rx_clr, fifo_tx_clr      FIFO clear pulses from FCR writes
//   cts, dsr, ri, dcd             asynchronous modem pins (active low)
//   INTR                          interrupt request (= ~IIR[0])
// -----------------------------------------------------------------------------
module uart_apb_regif #(
   parameter logic [15:0] DLR_RST  = 16'd1,
   parameter int          SYNC_STG = 2
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [2:0]  PADDR,
   input  logic [7:0]  PWDATA,
   output logic [7:0]  PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [15:0] DLR,
   output logic [7:0]  IER,
   output logic [7:0]  LCR,
   output logic [7:0]  FCR,
   output logic [7:0]  MCR,
   output logic        tx_push,
   output logic [7:0]  tx_data,
   output logic        rx_pop,
   input  logic [7:0]  rx_data,
   input  logic        rx_rdy,
   input  logic        oe,
   input  logic        pe,
   input  logic        fe,
   input  logic        bi,
   input  logic        thre,
   input  logic        temt,
   output logic        fifo_rx_clr,
   output logic        fifo_tx_clr,
   input  logic        cts,
   input  logic        dsr,
   input  logic        ri,
   input  logic        dcd,
   output logic        INTR
);

   // The APB setup phase is the ST_IDLE cycle with PSEL & ~PENABLE. ST_ACCESS
   // is the first access cycle. ST_WAIT is the extra cycle of an RBR read.
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_t;

   state_t      r_state, w_next;
   logic [15:0] r_dlr;
   logic [7:0]  r_ier, r_lcr, r_fcr, r_mcr, r_tx_data, r_iir;
   logic [3:0]  r_lsr_err, r_msr_dlt, r_msr_prev;
   logic        r_thre_q, r_thre_int;
   logic [3:0]  r_sync [SYNC_STG];
`ifdef UART_SCR_EN
   logic [7:0]  r_scr;
`endif

   logic       w_dlab, w_en, w_acc, w_wr, w_rd, w_unmapped, w_rbr_rd;
   logic       w_thr_wr, w_fcr_wr, w_lsr_rd, w_msr_rd, w_iir_rd, w_iir_clr;
   logic [7:0] w_lsr, w_msr, w_rd_mux;
   logic [3:0] w_mstat, w_mchg, w_iid;

   assign w_dlab = r_lcr[7];
   assign w_en   = PSEL & PENABLE;
   assign w_acc  = (r_state == ST_ACCESS) & w_en;
`ifdef UART_SCR_EN
   assign w_unmapped = 1'b0;
`else
   assign w_unmapped = (PADDR == 3'd7);
`endif
   assign w_rbr_rd  = w_acc & ~PWRITE & (PADDR == 3'd0) & ~w_dlab;
   assign w_wr      = w_acc &  PWRITE & ~w_unmapped;
   assign w_rd      = w_acc & ~PWRITE & ~w_unmapped;
   assign w_thr_wr  = w_wr & (PADDR == 3'd0) & ~w_dlab;
   assign w_fcr_wr  = w_wr & (PADDR == 3'd2);
   assign w_lsr_rd  = w_rd & (PADDR == 3'd5);
   assign w_msr_rd  = w_rd & (PADDR == 3'd6);
   assign w_iir_rd  = w_rd & (PADDR == 3'd2);
   // Only a read that returns the THRE identity acknowledges that interrupt.
   assign w_iir_clr = w_iir_rd & (r_iir[3:0] == 4'h2);

   // ---------------- bus FSM ----------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!PRESETn) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      w_next  = r_state;
      rx_pop  = 1'b0;
      PREADY  = 1'b1;
      PSLVERR = 1'b0;
      PRDATA  = 8'h00;
      case (r_state)
         ST_IDLE: if (PSEL && !PENABLE) w_next = ST_ACCESS;
         ST_ACCESS: begin
            if (!w_en) begin
               w_next = ST_IDLE;
            end else if (w_rbr_rd) begin
               // rx_data is only valid the cycle after the pop, so stretch one cycle.
               rx_pop = 1'b1;
               PREADY = 1'b0;
               w_next = ST_WAIT;
            end else begin
               w_next  = ST_IDLE;
               PSLVERR = w_unmapped;
               if (!PWRITE) PRDATA = w_rd_mux;
            end
         end
         ST_WAIT: begin
            PRDATA = rx_data;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rd_mux = 8'h00;
      case (PADDR)
         3'd0: w_rd_mux = w_dlab ? r_dlr[7:0] : 8'h00;
         3'd1: w_rd_mux = w_dlab ? r_dlr[15:8] : r_ier;
         3'd2: w_rd_mux = r_iir;
         3'd3: w_rd_mux = r_lcr;
         3'd4: w_rd_mux = r_mcr;
         3'd5: w_rd_mux = w_lsr;
         3'd6: w_rd_mux = w_msr;
`ifdef UART_SCR_EN
         3'd7: w_rd_mux = r_scr;
`endif
         default: w_rd_mux = 8'h00;
      endcase
   end

   // ---------------- configuration registers ----------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_dlr     <= DLR_RST;
         r_ier     <= 8'h00;
         r_lcr     <= 8'h00;
         r_fcr     <= 8'h00;
         r_mcr     <= 8'h00;
         r_tx_data <= 8'h00;
`ifdef UART_SCR_EN
         r_scr     <= 8'h00;
`endif
      end else begin
         if (w_thr_wr) r_tx_data <= PWDATA;
         if (w_wr) begin
            case (PADDR)
               3'd0: if (w_dlab) r_dlr[7:0] <= PWDATA;
               3'd1: if (w_dlab) r_dlr[15:8] <= PWDATA; else r_ier <= PWDATA;
               3'd2: r_fcr <= PWDATA & 8'hF9;   // clear bits are pulses, never stored
               3'd3: r_lcr <= PWDATA;
               3'd4: r_mcr <= PWDATA;
`ifdef UART_SCR_EN
               3'd7: r_scr <= PWDATA;
`endif
               default: ;
            endcase
         end
      end
   end

   assign tx_push     = w_thr_wr;
   // Present the new byte in the push cycle itself and hold it afterwards.
   assign tx_data     = w_thr_wr ? PWDATA : r_tx_data;
   assign fifo_rx_clr = w_fcr_wr & PWDATA[1];
   assign fifo_tx_clr = w_fcr_wr & PWDATA[2];

   // ---------------- LSR, MSR, THRE interrupt, IIR ----------------
   // Modem status in active-high form {dcd, ri, dsr, cts}. Loopback feeds MCR outputs back.
   assign w_mstat = r_mcr[4] ? {r_mcr[3], r_mcr[2], r_mcr[0], r_mcr[1]}
                             : ~r_sync[SYNC_STG-1];
   assign w_mchg  = {w_mstat[3] ^ r_msr_prev[3],
                     r_msr_prev[2] & ~w_mstat[2],          // RI: trailing edge only
                     w_mstat[1] ^ r_msr_prev[1],
                     w_mstat[0] ^ r_msr_prev[0]};

   assign w_lsr = {r_fcr[0] & (|r_lsr_err), temt, thre, r_lsr_err, rx_rdy};
   assign w_msr = {w_mstat, r_msr_dlt};

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < SYNC_STG; i++) r_sync[i] <= 4'hF;   // pins idle high
         r_msr_prev <= 4'h0;
         r_msr_dlt  <= 4'h0;
         r_lsr_err  <= 4'h0;
         r_thre_q   <= 1'b1;   // no fake rising edge when leaving reset
         r_thre_int <= 1'b0;
         r_iir      <= 8'h01;
      end else begin
         r_sync[0] <= {dcd, ri, dsr, cts};
         for (int i = 1; i < SYNC_STG; i++) r_sync[i] <= r_sync[i-1];
         r_msr_prev <= w_mstat;
         // When a new event coincides with the clearing read, the event wins.
         r_msr_dlt  <= (r_msr_dlt & {4{~w_msr_rd}}) | w_mchg;
         r_lsr_err  <= (r_lsr_err & {4{~w_lsr_rd}}) | {bi, fe, pe, oe};
         r_thre_q   <= thre;
         r_thre_int <= (thre & ~r_thre_q) | (r_thre_int & ~(w_thr_wr | w_iir_clr));
         r_iir      <= {{2{r_fcr[0]}}, 2'b00, w_iid};
      end
   end

   always_comb begin
      if      ((|r_lsr_err) && r_ier[2]) w_iid = 4'h6;
      else if (rx_rdy && r_ier[0])       w_iid = 4'h4;
      else if (r_thre_int && r_ier[1])   w_iid = 4'h2;
      else if ((|r_msr_dlt) && r_ier[3]) w_iid = 4'h0;
      else                               w_iid = 4'h1;
   end

   assign INTR = ~r_iir[0];
   assign DLR  = r_dlr;
   assign IER  = r_ier;
   assign LCR  = r_lcr;
   assign FCR  = r_fcr;
   assign MCR  = r_mcr;

endmodule

// File: tb/tb_uart_apb_regif.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_regif
//   Directed sequence with randomized data for uart_apb_regif. Expected values
//   come from a register-level model of the UART programming interface held in
//   this module.
// -----------------------------------------------------------------------------
module tb_uart_apb_regif;
   localparam int SYNC_STG = 2;
`ifdef UART_SCR_EN
   localparam bit SCR = 1'b1;
`else
   localparam bit SCR = 1'b0;
`endif

   logic        PCLK = 1'b0, PRESETn = 1'b0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [2:0]  PADDR = 3'd0;
   logic [7:0]  PWDATA = 8'h00, rx_data = 8'h00;
   logic        rx_rdy = 1'b0, oe = 1'b0, pe = 1'b0, fe = 1'b0, bi = 1'b0;
   logic        thre = 1'b1, temt = 1'b1;
   logic        cts = 1'b1, dsr = 1'b1, ri = 1'b1, dcd = 1'b1;
   logic [7:0]  PRDATA, IER, LCR, FCR, MCR, tx_data;
   logic [15:0] DLR;
   logic        PREADY, PSLVERR, tx_push, rx_pop, fifo_rx_clr, fifo_tx_clr, INTR;

   uart_apb_regif #(.DLR_RST(16'd1), .SYNC_STG(SYNC_STG)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .DLR(DLR), .IER(IER), .LCR(LCR),
      .FCR(FCR), .MCR(MCR), .tx_push(tx_push), .tx_data(tx_data),
      .rx_pop(rx_pop), .rx_data(rx_data), .rx_rdy(rx_rdy), .oe(oe), .pe(pe),
      .fe(fe), .bi(bi), .thre(thre), .temt(temt), .fifo_rx_clr(fifo_rx_clr),
      .fifo_tx_clr(fifo_tx_clr), .cts(cts), .dsr(dsr), .ri(ri), .dcd(dcd),
      .INTR(INTR)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0, errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse counters, sampled mid-cycle when inputs are stable.
   int         n_push = 0, n_pop = 0, n_rxclr = 0, n_txclr = 0;
   logic [7:0] last_tx = 8'h00;
   always @(negedge PCLK) begin
      if (tx_push === 1'b1) begin n_push++; last_tx = tx_data; end
      if (rx_pop === 1'b1) n_pop++;
      if (fifo_rx_clr === 1'b1) n_rxclr++;
      if (fifo_tx_clr === 1'b1) n_txclr++;
   end

   // ---------------- reference model ----------------
   logic [15:0] m_dlr;
   logic [7:0]  m_ier, m_lcr, m_fcr, m_mcr, m_scr;
   logic [3:0]  m_err, m_dlt, m_stat;   // m_stat/m_dlt use {dcd, ri, dsr, cts} order
   bit          m_thre_int;

   task automatic model_reset();
      m_dlr = 16'd1; m_ier = 0; m_lcr = 0; m_fcr = 0; m_mcr = 0; m_scr = 0;
      m_err = 0; m_dlt = 0; m_stat = 0; m_thre_int = 0;
   endtask

   function automatic logic [3:0] stat_now();
      if (m_mcr[4]) return {m_mcr[3], m_mcr[2], m_mcr[0], m_mcr[1]};
      return ~{dcd, ri, dsr, cts};
   endfunction

   task automatic msr_update();
      logic [3:0] n;
      n = stat_now();
      for (int b = 0; b < 4; b++) begin
         if (b == 2) begin
            if (m_stat[2] && !n[2]) m_dlt[2] = 1'b1;
         end else if (m_stat[b] != n[b]) begin
            m_dlt[b] = 1'b1;
         end
      end
      m_stat = n;
   endtask

   function automatic logic [7:0] exp_lsr();
      return {m_fcr[0] && (m_err != 0), temt, thre, m_err, rx_rdy};
   endfunction

   function automatic logic [7:0] exp_iir();
      logic [3:0] id;
      if (m_err != 0 && m_ier[2])      id = 4'h6;
      else if (rx_rdy && m_ier[0])     id = 4'h4;
      else if (m_thre_int && m_ier[1]) id = 4'h2;
      else if (m_dlt != 0 && m_ier[3]) id = 4'h0;
      else                             id = 4'h1;
      return {{2{m_fcr[0]}}, 2'b00, id};
   endfunction

   // ---------------- bus helpers ----------------
   task automatic tick();
      @(posedge PCLK); #2;
   endtask

   task automatic settle();
      repeat (SYNC_STG + 4) tick();
   endtask

   task automatic apb(input bit wr, input logic [2:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic err, output int waits);
      tick(); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      tick(); PENABLE = 1'b1;
      @(negedge PCLK);
      waits = 0;
      while (PREADY !== 1'b1 && waits < 8) begin waits++; @(negedge PCLK); end
      if (PREADY !== 1'b1) check("apb_timeout", 32'(PREADY), 32'd1);
      rd = PRDATA; err = PSLVERR;
      tick(); PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      int p0, r0, t0, w, exp_push;
      logic [7:0] rd;
      logic err;
      p0 = n_push; r0 = n_rxclr; t0 = n_txclr;
      exp_push = (a == 3'd0 && !m_lcr[7]) ? 1 : 0;
      apb(1'b1, a, d, rd, err, w);
      check($sformatf("wr%0d_slverr", a), 32'(err), 32'(a == 3'd7 && !SCR));
      check($sformatf("wr%0d_push", a), n_push - p0, exp_push);
      check($sformatf("wr%0d_rxclr", a), n_rxclr - r0, (a == 3'd2) ? 32'(d[1]) : 0);
      check($sformatf("wr%0d_txclr", a), n_txclr - t0, (a == 3'd2) ? 32'(d[2]) : 0);
      case (a)
         3'd0: if (m_lcr[7]) m_dlr[7:0] = d;
               else begin check("thr_tx_data", 32'(last_tx), 32'(d)); m_thre_int = 0; end
         3'd1: if (m_lcr[7]) m_dlr[15:8] = d; else m_ier = d;
         3'd2: m_fcr = d & 8'hF9;
         3'd3: m_lcr = d;
         3'd4: begin m_mcr = d; msr_update(); end
         3'd7: if (SCR) m_scr = d;
         default: ;
      endcase
   endtask

   task automatic do_read(input logic [2:0] a);
      logic [7:0] exp, rd;
      logic err;
      int w, p0, exp_pop;
      p0 = n_pop; exp_pop = 0;
      case (a)
         3'd0: if (m_lcr[7]) exp = m_dlr[7:0]; else begin exp = rx_data; exp_pop = 1; end
         3'd1: exp = m_lcr[7] ? m_dlr[15:8] : m_ier;
         3'd2: exp = exp_iir();
         3'd3: exp = m_lcr;
         3'd4: exp = m_mcr;
         3'd5: exp = exp_lsr();
         3'd6: exp = {m_stat, m_dlt};
         default: exp = SCR ? m_scr : 8'h00;
      endcase
      apb(1'b0, a, 8'h00, rd, err, w);
      check($sformatf("rd%0d_data", a), 32'(rd), 32'(exp));
      check($sformatf("rd%0d_slverr", a), 32'(err), 32'(a == 3'd7 && !SCR));
      check($sformatf("rd%0d_pops", a), n_pop - p0, exp_pop);
      check($sformatf("rd%0d_waits", a), w, exp_pop);
      if (a == 3'd2 && exp[3:0] == 4'h2) m_thre_int = 0;
      if (a == 3'd5) m_err = {bi, fe, pe, oe};   // inputs still high re-latch
      if (a == 3'd6) m_dlt = 0;
   endtask

   task automatic chk_cfg(input string tag);
      check({tag, "_DLR"}, 32'(DLR), 32'(m_dlr));
      check({tag, "_IER"}, 32'(IER), 32'(m_ier));
      check({tag, "_LCR"}, 32'(LCR), 32'(m_lcr));
      check({tag, "_FCR"}, 32'(FCR), 32'(m_fcr));
      check({tag, "_MCR"}, 32'(MCR), 32'(m_mcr));
   endtask

   task automatic chk_irq(input string tag);
      logic [7:0] e;
      e = exp_iir();
      check({tag, "_INTR"}, 32'(INTR), 32'(!e[0]));
   endtask

   task automatic err_pulse(input int k);
      tick();
      case (k)
         0: oe = 1'b1;
         1: pe = 1'b1;
         2: fe = 1'b1;
         default: bi = 1'b1;
      endcase
      m_err[k] = 1'b1;
      tick(); oe = 0; pe = 0; fe = 0; bi = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] v;
      model_reset();
      repeat (3) @(negedge PCLK);
      check("rst_PRDATA", 32'(PRDATA), 0);
      check("rst_PREADY", 32'(PREADY), 1);
      check("rst_PSLVERR", 32'(PSLVERR), 0);
      check("rst_INTR", 32'(INTR), 0);
      check("rst_pulses", 32'({tx_push, rx_pop, fifo_rx_clr, fifo_tx_clr}), 0);
      chk_cfg("rst");
      tick(); PRESETn = 1'b1;
      settle();

      // Reset view of every readable offset.
      for (int a = 0; a < 7; a++) begin
         rx_data = 8'($urandom);
         do_read(3'(a));
      end

      // Divisor programming via DLAB.
      do_write(3, 8'h80); do_write(0, 8'h1A); do_write(1, 8'h00); do_write(3, 8'h03);
      chk_cfg("dlr");
      do_read(3);

      // Random configuration round trips.
      for (int i = 0; i < 6; i++) begin
         do_write(3, 8'h80 | 8'($urandom));
         do_write(0, 8'($urandom)); do_write(1, 8'($urandom));
         do_read(0); do_read(1);
         do_write(3, 8'($urandom) & 8'h7F);
         do_write(1, 8'($urandom)); do_write(2, 8'($urandom));
         do_write(4, 8'($urandom) & 8'hEF); do_write(7, 8'($urandom));
         for (int a = 1; a < 8; a++) do_read(3'(a));
         chk_cfg("cfg");
      end
      do_write(3, 8'h03); do_write(4, 8'h00);

      // THRE interrupt: set by rising edge, cleared by IIR read or THR write.
      do_write(1, 8'h02);
      tick(); thre = 0; tick(); tick(); thre = 1; m_thre_int = 1;
      settle(); chk_irq("thre1");
      do_read(2); do_read(2);
      tick(); thre = 0; tick(); tick(); thre = 1; m_thre_int = 1;
      settle(); chk_irq("thre2");
      do_write(0, 8'h55);
      check("tx_data_hold", 32'(tx_data), 32'h55);
      do_read(2);
      for (int i = 0; i < 3; i++) begin
         v = 8'($urandom);
         do_write(0, v);
         check("tx_data_rand", 32'(tx_data), 32'(v));
      end

      // RBR reads with data ready.
      rx_rdy = 1; do_write(1, 8'h01); settle(); chk_irq("rxrdy");
      do_read(2);
      for (int i = 0; i < 3; i++) begin rx_data = 8'($urandom); do_read(0); end

      // Line status errors.
      do_write(1, 8'h05);
      err_pulse(1); settle(); chk_irq("pe");
      do_read(2); do_read(5); do_read(5); do_read(2);
      for (int i = 0; i < 4; i++) begin
         err_pulse(int'($urandom_range(0, 3)));
         settle(); do_read(2); do_read(5); do_read(5);
      end
      // Error held high across the clearing read stays latched.
      tick(); fe = 1; m_err[2] = 1; tick();
      do_read(5);
      tick(); fe = 0; settle();
      do_read(5); do_read(5);

      // Modem status.
      rx_rdy = 0; do_write(1, 8'h08);
      tick(); cts = 0; msr_update(); settle(); chk_irq("cts");
      do_read(6); do_read(2); do_read(6); do_read(2);
      tick(); ri = 0; msr_update(); settle(); do_read(6);
      tick(); ri = 1; msr_update(); settle(); do_read(6); do_read(2);
      for (int i = 0; i < 4; i++) begin
         tick(); {dcd, ri, dsr, cts} = 4'($urandom); msr_update();
         settle(); do_read(2); do_read(6);
      end
      do_write(4, 8'h10 | (8'($urandom) & 8'h0F)); settle();
      do_read(6); do_read(6);
      tick(); {dcd, ri, dsr, cts} = 4'hF; msr_update();
      do_write(4, 8'h00); settle(); do_read(6); do_read(2);

      // Read-only offsets ignore writes; offset 7 per build.
      do_write(5, 8'($urandom)); do_write(6, 8'($urandom));
      do_read(5); do_read(6);
      do_write(7, 8'hA5); do_read(7);

      // Reset in the middle of an RBR read.
      rx_rdy = 1;
      tick(); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 3'd0;
      tick(); PENABLE = 1;
      @(negedge PCLK);
      check("mid_pop", 32'(rx_pop), 1);
      check("mid_ready", 32'(PREADY), 0);
      #1 PRESETn = 0;
      #1;
      check("rstmid_pop", 32'(rx_pop), 0);
      check("rstmid_ready", 32'(PREADY), 1);
      PSEL = 0; PENABLE = 0;
      model_reset();
      chk_cfg("rstmid");
      tick(); PRESETn = 1;
      settle();
      do_read(2); do_read(5); do_read(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
